uart_rx_oversampler: RTL and testbench
======================================

# uart_rx_oversampler

Parametrised oversampling bit sampler for the UART receiver. It synchronises RX_IN and runs its own per-bit edge counter. It captures NUM_SAMPLES consecutive oversamples centred on the bit midpoint, then majority-votes them. It sits between the RX pin and the RX control FSM, and gives the FSM a registered bit, a one-cycle valid strobe, a noise flag and an end-of-bit strobe.

## Interface
Parameters:
- PRESCALE_W, default 6: width of Prescale and edge_count.
- NUM_SAMPLES, default 3: samples voted per bit. Must be odd, 3 or 5.

Ports:
- CLK, input, 1: clock.
- RST, input, 1: reset, asynchronous, active-low.
- RX_IN, input, 1: serial line. Asynchronous. Idle level is 1.
- Prescale, input, PRESCALE_W: oversampling ratio. Legal values are even, from 8 to 2^PRESCALE_W-2.
- enable, input, 1: level enable from the RX FSM. High means a bit period is in progress.
- edge_count, output, PRESCALE_W: current oversample index within the bit.
- bit_done, output, 1: one-cycle pulse when edge_count equals P-1.
- sampled_bit, output, 1: registered majority result. Holds its value between updates.
- sample_valid, output, 1: one-cycle pulse when sampled_bit updates.
- noise_flag, output, 1: registered, updated with sampled_bit. Set to 1 when the samples were not unanimous.

## Operation
- Synchroniser: two flops. rx_sync is RX_IN delayed by 2 CLK. Both flops reset to 1.
- Prescale latch: P is captured on the first enable-high cycle. It is held while enable stays high. Changes to Prescale mid-bit are ignored.
- Edge counter:
  - enable low: counter is 0.
  - enable high: counts 0,1,…,P-1, then wraps to 0. It runs continuously across consecutive bits.
- Sample positions:
  - mid = (P>>1)-1, computed at PRESCALE_W width.
  - Positions are mid-(NUM_SAMPLES-1)/2 through mid+(NUM_SAMPLES-1)/2.
  - When edge_count equals position k, rx_sync is stored into sample slot k.
- Vote:
  - Triggered the cycle after the last position (edge_count = last+1).
  - Registers sampled_bit = majority of the slots.
  - Registers noise_flag = 1 unless all slots are equal.
  - Pulses sample_valid for exactly 1 cycle.
- Enable low:
  - Counter goes to 0 and all sample slots go to 1.
  - No sample_valid pulse is produced.
  - sampled_bit and noise_flag hold their last values.
- Illegal Prescale (odd, or below 8): output values are unspecified. The counter must still wrap at P-1 and never lock up.
- Reset values:
  - sampled_bit = 1.
  - sample_valid = 0, noise_flag = 0, bit_done = 0, edge_count = 0.
  - All sample slots = 1.
  - Prescale latch = 0.

## Timing
- Pin to sample: 2 cycles of synchroniser latency.
- Vote latency: 1 cycle after the last sample edge. Example: P=8, N=3 gives positions 2,3,4 and sample_valid in the cycle where edge_count=5.
- bit_done is combinational from the counter register, with no added latency. It coincides with edge_count=P-1.
- Exactly one sample_valid pulse and one bit_done pulse occur per full bit period.
- Enable falling at any edge_count: the next cycle shows edge_count=0, and the pending vote is cancelled.
- Enable rising again: the count restarts at 0 and P is re-latched.
- RST asserted mid-bit: all state returns to reset values immediately (asynchronous). Release is synchronous to CLK.

## Structure
- Shared package uart_rx_pkg holds:
  - the legal Prescale minimum (8);
  - the synchroniser depth constant (2);
  - the allowed NUM_SAMPLES values.
- Sub-module uart_majority_vote:
  - purely combinational;
  - NUM_SAMPLES-bit input;
  - outputs majority and not-unanimous.
- Everything else (synchroniser, counter, latch, slots, output registers) lives in the top module.

## Test plan
- Reset: hold RST low with RX_IN toggling. Expect sampled_bit=1, sample_valid=0, noise_flag=0, edge_count=0, bit_done=0.
- P=8, N=3, RX_IN=0 settled, enable high for 16 cycles:
  - edge_count runs 0..7, 0..7;
  - sample_valid pulses at edge_count=5, twice in total, with sampled_bit=0 and noise_flag=0;
  - bit_done pulses at 7.
- P=8, N=3 glitch: rx_sync=1 only at edge_count=3. Expect sampled_bit=0, noise_flag=1.
- P=16, N=5: positions 5..9, rx_sync pattern 1,1,0,0,1. Expect sampled_bit=1 and noise_flag=1, valid at edge_count=10.
- enable dropped at edge_count=3:
  - no sample_valid pulse;
  - edge_count=0 next cycle;
  - sampled_bit holds its previous value.
- Prescale changed from 8 to 16 while enable is high:
  - the counter still wraps at 7;
  - the new value takes effect only after enable goes low then high.
- Separately, RST pulsed at edge_count=4: outputs return to reset values.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receive path: Prescale limits, synchroniser depth, vote sizes.
// Latency: none (declarations only).
// Backpressure: not applicable.
package uart_rx_pkg;

  // Smallest oversampling ratio the receive path is designed for
  localparam int PRESCALE_MIN = 8;

  // Number of flops between the asynchronous RX pin and the sampling logic
  localparam int SYNC_DEPTH = 2;

  // Supported sample-window sizes for the majority vote
  localparam int NUM_SAMPLES_MIN = 3;
  localparam int NUM_SAMPLES_MAX = 5;

  // True when n is a supported vote size (odd, 3 or 5)
  function automatic bit num_samples_legal(input int n);
    return (n == 3) || (n == 5);
  endfunction

  // True when p is a usable oversampling ratio for a counter of width w
  function automatic bit prescale_legal(input int p, input int w);
    return (p >= PRESCALE_MIN) && ((p % 2) == 0) && (p <= (2 ** w) - 2);
  endfunction

endpackage

// File: rtl/uart_rx_oversampler_if.sv
// Bundle between the RX pin / RX control FSM and the oversampling bit sampler.
// Latency: none (wires only).
// Backpressure: none; strobes are single-cycle and must be consumed when seen.
interface uart_rx_oversampler_if #(
  parameter int PRESCALE_W = 6
);

  logic                  RX_IN;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  enable;
  logic [PRESCALE_W-1:0] edge_count;
  logic                  bit_done;
  logic                  sampled_bit;
  logic                  sample_valid;
  logic                  noise_flag;

  // Controller side: owns the pin, the ratio and the bit-period enable
  modport master (
    output RX_IN, Prescale, enable,
    input  edge_count, bit_done, sampled_bit, sample_valid, noise_flag
  );

  // Sampler side
  modport slave (
    input  RX_IN, Prescale, enable,
    output edge_count, bit_done, sampled_bit, sample_valid, noise_flag
  );

endinterface

// File: rtl/uart_majority_vote.sv
// Majority vote and unanimity check over a small odd-sized set of line samples.
// Latency: purely combinational.
// Backpressure: none.
module uart_majority_vote
  import uart_rx_pkg::*;
#(
  parameter int NUM_SAMPLES = NUM_SAMPLES_MIN
) (
  input  logic [NUM_SAMPLES-1:0] samples,
  output logic                   majority,
  output logic                   not_unanimous
);

  localparam int CW = $clog2(NUM_SAMPLES + 1);

  logic [CW-1:0] ones;

  // Population count of the sample window
  always_comb begin
    ones = '0;
    for (int i = 0; i < NUM_SAMPLES; i++) begin
      ones = ones + CW'(samples[i]);
    end
  end

  // More than half the samples high wins; any disagreement flags noise
  assign majority      = (ones > CW'(NUM_SAMPLES / 2));
  assign not_unanimous = (|samples) && !(&samples);

endmodule

// File: rtl/uart_rx_oversampler.sv
// Oversampling bit sampler: synchronises RX_IN, counts oversamples per bit, votes a window centred on mid-bit.
// Latency: 2 cycles pin-to-sample; sampled_bit/sample_valid appear 1 cycle after the last sample edge.
// Backpressure: none; sample_valid and bit_done are single-cycle strobes, enable low aborts the bit.
module uart_rx_oversampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W  = 6,
  parameter int NUM_SAMPLES = 3
) (
  input logic                  CLK,
  input logic                  RST,
  uart_rx_oversampler_if.slave bus
);

  localparam int HALF = (NUM_SAMPLES - 1) / 2;

  typedef logic [PRESCALE_W-1:0] cnt_t;

  logic [SYNC_DEPTH-1:0]  sync_q;
  logic                   rx_sync;
  logic                   en_q;
  logic                   first_cycle;
  cnt_t                   prescale_q;
  cnt_t                   p_eff;
  cnt_t                   p_last;
  cnt_t                   mid;
  cnt_t                   first_pos;
  cnt_t                   last_pos;
  cnt_t                   cnt_q;
  logic [NUM_SAMPLES-1:0] slots_q;
  logic [NUM_SAMPLES-1:0] vote_in;
  logic                   vote_now;
  logic                   vote_maj;
  logic                   vote_noisy;
  logic                   sampled_bit_q;
  logic                   sample_valid_q;
  logic                   noise_flag_q;

  // Two-flop synchroniser; idle line level is 1 so flops reset high
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], bus.RX_IN};
    end
  end

  assign rx_sync = sync_q[SYNC_DEPTH-1];

  // Track enable history and latch Prescale on the first enable-high cycle only
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      en_q       <= 1'b0;
      prescale_q <= '0;
    end else begin
      en_q <= bus.enable;
      if (first_cycle) begin
        prescale_q <= bus.Prescale;
      end
    end
  end

  // On the very first cycle the latch is not loaded yet, so use the live input
  assign first_cycle = bus.enable && !en_q;
  assign p_eff       = first_cycle ? bus.Prescale : prescale_q;
  assign p_last      = p_eff - cnt_t'(1);
  assign mid         = (p_eff >> 1) - cnt_t'(1);
  assign first_pos   = mid - cnt_t'(HALF);
  assign last_pos    = mid + cnt_t'(HALF);

  // Free-running oversample counter; >= keeps odd/tiny ratios from ever running away
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else if (!bus.enable) begin
      cnt_q <= '0;
    end else if (cnt_q >= p_last) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + cnt_t'(1);
    end
  end

  // Capture the synchronised line into the slot matching the current sample position
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      slots_q <= '1;
    end else if (!bus.enable) begin
      slots_q <= '1;
    end else begin
      for (int k = 0; k < NUM_SAMPLES; k++) begin
        if (cnt_q == first_pos + cnt_t'(k)) begin
          slots_q[k] <= rx_sync;
        end
      end
    end
  end

  // The last slot is still being written on the vote edge, so vote on the live sample instead
  always_comb begin
    vote_in                = slots_q;
    vote_in[NUM_SAMPLES-1] = rx_sync;
  end

  assign vote_now = bus.enable && (cnt_q == last_pos);

  uart_majority_vote #(
    .NUM_SAMPLES(NUM_SAMPLES)
  ) u_vote (
    .samples      (vote_in),
    .majority     (vote_maj),
    .not_unanimous(vote_noisy)
  );

  // Register the vote so result, noise flag and strobe all appear together at last+1
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sampled_bit_q  <= 1'b1;
      sample_valid_q <= 1'b0;
      noise_flag_q   <= 1'b0;
    end else begin
      sample_valid_q <= vote_now;
      if (vote_now) begin
        sampled_bit_q <= vote_maj;
        noise_flag_q  <= vote_noisy;
      end
    end
  end

  assign bus.edge_count   = cnt_q;
  assign bus.bit_done     = bus.enable && (cnt_q == p_last);
  assign bus.sampled_bit  = sampled_bit_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.noise_flag   = noise_flag_q;

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Bench for uart_rx_oversampler: N=3 and N=5 instances share stimulus, a window model feeds per-DUT queues.
// Latency: expected votes carry the absolute cycle and edge_count at which the strobe must appear.
// Backpressure: none; the monitors pop whenever a sample_valid strobe is seen.
module tb_uart_rx_oversampler;

  localparam int PW = 6;

  logic          CLK      = 1'b0;
  logic          RST      = 1'b0;
  logic          rx_in    = 1'b1;
  logic [PW-1:0] prescale = '0;
  logic          enable   = 1'b0;

  uart_rx_oversampler_if #(.PRESCALE_W(PW)) bus3 ();
  uart_rx_oversampler_if #(.PRESCALE_W(PW)) bus5 ();

  assign bus3.RX_IN    = rx_in;
  assign bus3.Prescale = prescale;
  assign bus3.enable   = enable;
  assign bus5.RX_IN    = rx_in;
  assign bus5.Prescale = prescale;
  assign bus5.enable   = enable;

  uart_rx_oversampler #(.PRESCALE_W(PW), .NUM_SAMPLES(3)) dut3 (
    .CLK(CLK), .RST(RST), .bus(bus3)
  );
  uart_rx_oversampler #(.PRESCALE_W(PW), .NUM_SAMPLES(5)) dut5 (
    .CLK(CLK), .RST(RST), .bus(bus5)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic b;
    logic n;
    int   ec;
    int   cyc_at;
  } exp_t;

  exp_t q3[$];
  exp_t q5[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic exp_bit[2]   = '{1'b1, 1'b1};
  logic exp_noise[2] = '{1'b0, 1'b0};
  bit   line_v[0:511];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic mon_pop(input string tag, input exp_t e, input logic b, input logic n,
                         input logic [PW-1:0] ec);
    check({tag, " sampled_bit"}, b, e.b);
    check({tag, " noise_flag"}, n, e.n);
    check({tag, " valid edge_count"}, ec, e.ec);
    check({tag, " valid cycle"}, cyc, e.cyc_at);
  endtask

  // Scoreboard monitors: every strobe must match the oldest outstanding expected vote
  always @(negedge CLK) begin
    if (RST && bus3.sample_valid) begin
      if (q3.size() == 0) check("n3 unexpected sample_valid", 1, 0);
      else mon_pop("n3", q3.pop_front(), bus3.sampled_bit, bus3.noise_flag, bus3.edge_count);
    end
  end

  always @(negedge CLK) begin
    if (RST && bus5.sample_valid) begin
      if (q5.size() == 0) check("n5 unexpected sample_valid", 1, 0);
      else mon_pop("n5", q5.pop_front(), bus5.sampled_bit, bus5.noise_flag, bus5.edge_count);
    end
  end

  // Reference: line_v[k] is the synchronised line seen in window cycle k; a bit votes
  // only if its last sample cycle lies inside the enabled (and unreset) part of the window
  task automatic model_window(input int p, input int lim, input int base);
    for (int v = 0; v < 2; v++) begin
      int ns;
      int h;
      int first;
      int last;
      ns    = (v == 0) ? 3 : 5;
      h     = (ns - 1) / 2;
      first = p / 2 - 1 - h;
      last  = p / 2 - 1 + h;
      for (int b = 0; b * p + last < lim; b++) begin
        int   ones;
        exp_t e;
        ones = 0;
        for (int j = 0; j < ns; j++) ones += int'(line_v[b * p + first + j]);
        e.b      = (2 * ones > ns);
        e.n      = (ones != 0) && (ones != ns);
        e.ec     = last + 1;
        e.cyc_at = base + b * p + last + 1;
        if (v == 0) q3.push_back(e);
        else q5.push_back(e);
        exp_bit[v]   = e.b;
        exp_noise[v] = e.n;
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " n3 sampled_bit"}, bus3.sampled_bit, 1);
    check({tag, " n3 sample_valid"}, bus3.sample_valid, 0);
    check({tag, " n3 noise_flag"}, bus3.noise_flag, 0);
    check({tag, " n3 edge_count"}, bus3.edge_count, 0);
    check({tag, " n3 bit_done"}, bus3.bit_done, 0);
    check({tag, " n5 sampled_bit"}, bus5.sampled_bit, 1);
    check({tag, " n5 sample_valid"}, bus5.sample_valid, 0);
    check({tag, " n5 noise_flag"}, bus5.noise_flag, 0);
    check({tag, " n5 edge_count"}, bus5.edge_count, 0);
    check({tag, " n5 bit_done"}, bus5.bit_done, 0);
  endtask

  task automatic fill_const(input bit val);
    for (int i = 0; i < 512; i++) line_v[i] = val;
  endtask

  task automatic fill_random(input int p);
    bit lvl;
    lvl = 1'b0;
    for (int i = 0; i < 512; i++) begin
      if (i % p == 0) lvl = 1'($urandom_range(0, 1));
      line_v[i] = ($urandom_range(0, 5) == 0) ? ~lvl : lvl;
    end
  endtask

  // One enable window of L cycles; optional mid-window Prescale change and reset pulse
  task automatic run_window(input int p, input int L, input int chg_at, input int p_new,
                            input int rst_at);
    int lim;
    int base;
    lim      = (rst_at >= 0) ? rst_at : L;
    prescale = PW'(p);
    rx_in    = line_v[0];
    @(posedge CLK); #1;
    rx_in = line_v[1];
    @(posedge CLK); #1;
    base = cyc;
    model_window(p, lim, base);
    enable = 1'b1;
    for (int k = 0; k < L; k++) begin
      rx_in = line_v[k + 2];
      if (k == chg_at) prescale = PW'(p_new);
      @(negedge CLK);
      check("n3 edge_count", bus3.edge_count, k % p);
      check("n5 edge_count", bus5.edge_count, k % p);
      check("n3 bit_done", bus3.bit_done, (k % p) == p - 1);
      check("n5 bit_done", bus5.bit_done, (k % p) == p - 1);
      if (k == rst_at) begin
        #2 RST = 1'b0;
        #1 check_reset_state("mid-bit reset");
        enable = 1'b0;
        rx_in  = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b1;
        exp_bit   = '{1'b1, 1'b1};
        exp_noise = '{1'b0, 1'b0};
        check("n3 queue drained at reset", q3.size(), 0);
        check("n5 queue drained at reset", q5.size(), 0);
        return;
      end
      @(posedge CLK); #1;
    end
    enable = 1'b0;
    rx_in  = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    check("n3 edge_count after enable low", bus3.edge_count, 0);
    check("n5 edge_count after enable low", bus5.edge_count, 0);
    check("n3 bit_done idle", bus3.bit_done, 0);
    check("n3 sampled_bit hold", bus3.sampled_bit, exp_bit[0]);
    check("n5 sampled_bit hold", bus5.sampled_bit, exp_bit[1]);
    check("n3 noise_flag hold", bus3.noise_flag, exp_noise[0]);
    check("n5 noise_flag hold", bus5.noise_flag, exp_noise[1]);
    check("n3 no pending vote", q3.size(), 0);
    check("n5 no pending vote", q5.size(), 0);
    @(posedge CLK); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, run did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with the line toggling
    for (int i = 0; i < 4; i++) begin
      rx_in = 1'($urandom_range(0, 1));
      @(negedge CLK);
      check_reset_state("reset");
      @(posedge CLK); #1;
    end
    RST   = 1'b1;
    rx_in = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;

    // P=8, steady 0 for two bits
    fill_const(1'b0);
    run_window(8, 16, -1, 0, -1);

    // P=8, one-sample glitch at edge_count 3
    fill_const(1'b0);
    line_v[3] = 1'b1;
    run_window(8, 8, -1, 0, -1);

    // P=16, line 1,1,0,0,1 across positions 5..9
    fill_const(1'b0);
    line_v[5] = 1'b1; line_v[6] = 1'b1; line_v[7] = 1'b0; line_v[8] = 1'b0; line_v[9] = 1'b1;
    run_window(16, 16, -1, 0, -1);

    // Enable dropped at edge_count 3: nothing votes, outputs hold
    fill_const(1'b1);
    run_window(8, 3, -1, 0, -1);

    // Prescale moved to 16 mid-window is ignored, then takes effect in the next window
    fill_random(8);
    run_window(8, 20, 3, 16, -1);
    fill_random(16);
    run_window(16, 32, -1, 0, -1);

    // Reset pulsed at edge_count 4 after a 0 bit
    fill_const(1'b0);
    run_window(8, 8, -1, 0, -1);
    run_window(8, 8, -1, 0, 4);

    // Randomised windows over the legal Prescale range
    for (int t = 0; t < 20; t++) begin
      int p;
      p = 2 * $urandom_range(4, 31);
      fill_random(p);
      run_window(p, $urandom_range(1, 3 * p), -1, 0, -1);
    end

    check("n3 final queue empty", q3.size(), 0);
    check("n5 final queue empty", q5.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
